// File: rtl/cprs_col_acc.sv
// Column compressor-accumulator: popcount each valid N-bit column and
// fold it into a framed signed accumulator (add or MSB-first shift-add).
module cprs_col_acc #(
  parameter int N     = 7,
  parameter int ACC_W = 16,
  parameter int SAT   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_first,
  input  logic             in_last,
  input  logic             in_neg,
  input  logic             mode,
  input  logic [N-1:0]     in_bits,
  output logic             out_valid,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf,
  output logic             drop
);

  localparam int CNT_W = $clog2(N + 1);
  localparam int W2    = ACC_W + 2;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] ACCUM = 1'b1;

  localparam logic signed [W2-1:0] MAXV =
    {3'b000, {(ACC_W-1){1'b1}}};
  localparam logic signed [W2-1:0] MINV =
    {3'b111, {(ACC_W-1){1'b0}}};

  logic [CNT_W-1:0] pop;

  always_comb begin
    pop = '0;
    for (int i = 0; i < N; i++) begin
      pop = pop + CNT_W'(in_bits[i]);
    end
  end

  logic             s1_valid;
  logic             s1_first;
  logic             s1_last;
  logic             s1_neg;
  logic             s1_mode;
  logic [CNT_W-1:0] s1_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_neg   <= 1'b0;
      s1_mode  <= 1'b0;
      s1_cnt   <= '0;
    end else begin
      s1_valid <= in_valid;
      s1_first <= in_first;
      s1_last  <= in_last;
      s1_neg   <= in_neg;
      s1_mode  <= mode;
      s1_cnt   <= pop;
    end
  end

  logic [0:0]       state;
  logic [ACC_W-1:0] acc;
  logic             mode_q;
  logic             ovf;

  logic signed [W2-1:0] acc_x;
  logic signed [W2-1:0] base;
  logic signed [W2-1:0] cnt_x;
  logic signed [W2-1:0] sum_w;
  logic                 hi;
  logic                 lo;
  logic [ACC_W-1:0]     res;
  logic                 take;
  logic                 drop_n;
  logic                 ovf_n;

  // Wide arithmetic keeps 2*acc + cnt exact before the range check.
  always_comb begin
    acc_x  = {{2{acc[ACC_W-1]}}, acc};
    cnt_x  = {{(W2-CNT_W){1'b0}}, s1_cnt};
    base   = '0;
    if (!s1_first) begin
      base = mode_q ? (acc_x <<< 1) : acc_x;
    end
    sum_w  = s1_neg ? (base - cnt_x) : (base + cnt_x);
    hi     = sum_w > MAXV;
    lo     = sum_w < MINV;
    res    = sum_w[ACC_W-1:0];
    if (SAT != 0) begin
      if (hi) res = MAXV[ACC_W-1:0];
      if (lo) res = MINV[ACC_W-1:0];
    end
    ovf_n  = (s1_first ? 1'b0 : ovf) | hi | lo;
    take   = s1_valid && (s1_first || state == ACCUM);
    drop_n = s1_valid &&
             ((state == IDLE) ? !s1_first : s1_first);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      mode_q    <= 1'b0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_ovf   <= 1'b0;
      drop      <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      drop      <= drop_n;
      if (take) begin
        acc <= res;
        ovf <= ovf_n;
        if (s1_first) mode_q <= s1_mode;
        if (s1_last) begin
          state     <= IDLE;
          out_valid <= 1'b1;
          out_sum   <= res;
          out_ovf   <= ovf_n;
        end else begin
          state <= ACCUM;
        end
      end
    end
  end

endmodule

// File: tb/tb_cprs_col_acc.sv
// Bench: three configurations (16-bit sat, 6-bit sat, 6-bit wrap) share
// one stimulus stream and are checked every cycle against a frame model.
module tb_cprs_col_acc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_first = 1'b0;
  logic       in_last = 1'b0;
  logic       in_neg = 1'b0;
  logic       mode = 1'b0;
  logic [6:0] in_bits = '0;

  logic        ovv[3];
  logic        drp[3];
  logic        ovf[3];
  logic [15:0] sa;
  logic [5:0]  sb;
  logic [5:0]  sc;

  cprs_col_acc #(.N(7), .ACC_W(16), .SAT(1)) u_a (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .in_first(in_first), .in_last(in_last), .in_neg(in_neg),
    .mode(mode), .in_bits(in_bits), .out_valid(ovv[0]),
    .out_sum(sa), .out_ovf(ovf[0]), .drop(drp[0]));

  cprs_col_acc #(.N(7), .ACC_W(6), .SAT(1)) u_b (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .in_first(in_first), .in_last(in_last), .in_neg(in_neg),
    .mode(mode), .in_bits(in_bits), .out_valid(ovv[1]),
    .out_sum(sb), .out_ovf(ovf[1]), .drop(drp[1]));

  cprs_col_acc #(.N(7), .ACC_W(6), .SAT(0)) u_c (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .in_first(in_first), .in_last(in_last), .in_neg(in_neg),
    .mode(mode), .in_bits(in_bits), .out_valid(ovv[2]),
    .out_sum(sc), .out_ovf(ovf[2]), .drop(drp[2]));

  int aw[3]  = '{16, 6, 6};
  bit sat[3] = '{1'b1, 1'b1, 1'b0};

  // Frame model state
  bit m_act[3];
  bit m_mode[3];
  bit m_ovf[3];
  int m_acc[3];
  int h_sum[3];
  bit h_ovf[3];

  // Expectation for the beat currently in flight
  bit p_val[3];
  bit p_drop[3];
  int p_sum[3];
  bit p_ovf[3];

  int total = 0;
  int bad = 0;

  task automatic chk(string tag, int c, int obs, int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s[%0d] observed=%0d expected=%0d",
             tag, c, obs, exp);
    end
  endtask

  function automatic int obs_sum(int c);
    if (c == 0) return int'($signed(sa));
    if (c == 1) return int'($signed(sb));
    return int'($signed(sc));
  endfunction

  function automatic void model(int c, bit v, bit f, bit l,
                                bit n, bit m, logic [6:0] b,
                                output bit nv, output bit nd);
    int cnt;
    int x;
    int lim;
    cnt = $countones(b);
    lim = 1 << (aw[c] - 1);
    nv = 1'b0;
    nd = 1'b0;
    if (!v) return;
    if (f) begin
      nd = m_act[c];
      m_mode[c] = m;
      m_ovf[c] = 1'b0;
      x = 0;
    end else if (!m_act[c]) begin
      nd = 1'b1;
      return;
    end else begin
      x = m_mode[c] ? 2 * m_acc[c] : m_acc[c];
    end
    x = n ? x - cnt : x + cnt;
    if (x >= lim || x < -lim) begin
      m_ovf[c] = 1'b1;
      if (sat[c]) begin
        x = (x >= lim) ? lim - 1 : -lim;
      end else begin
        x = x & (2 * lim - 1);
        if (x >= lim) x = x - 2 * lim;
      end
    end
    m_acc[c] = x;
    if (l) begin
      nv = 1'b1;
      m_act[c] = 1'b0;
      h_sum[c] = x;
      h_ovf[c] = m_ovf[c];
    end else begin
      m_act[c] = 1'b1;
    end
  endfunction

  task automatic check_all();
    for (int c = 0; c < 3; c++) begin
      chk("out_valid", c, int'(ovv[c]), int'(p_val[c]));
      chk("drop", c, int'(drp[c]), int'(p_drop[c]));
      chk("out_sum", c, obs_sum(c), p_sum[c]);
      chk("out_ovf", c, int'(ovf[c]), int'(p_ovf[c]));
    end
  endtask

  task automatic step(bit v, bit f, bit l, bit n, bit m,
                      logic [6:0] b);
    bit nv[3];
    bit nd[3];
    @(negedge clk);
    rst = 1'b0;
    in_valid = v;
    in_first = f;
    in_last = l;
    in_neg = n;
    mode = m;
    in_bits = b;
    for (int c = 0; c < 3; c++) model(c, v, f, l, n, m, b, nv[c], nd[c]);
    @(posedge clk);
    #1;
    check_all();
    for (int c = 0; c < 3; c++) begin
      p_val[c] = nv[c];
      p_drop[c] = nd[c];
      p_sum[c] = h_sum[c];
      p_ovf[c] = h_ovf[c];
    end
  endtask

  task automatic idle(int k);
    for (int i = 0; i < k; i++) step(0, 0, 0, 0, 0, 7'h00);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      m_act[c] = 1'b0;
      m_acc[c] = 0;
      m_ovf[c] = 1'b0;
      h_sum[c] = 0;
      h_ovf[c] = 1'b0;
      p_val[c] = 1'b0;
      p_drop[c] = 1'b0;
      p_sum[c] = 0;
      p_ovf[c] = 1'b0;
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    do_reset();
    do_reset();
    idle(2);

    // single plane, positive then negated
    step(1, 1, 1, 0, 0, 7'b1011011);
    step(1, 1, 1, 1, 0, 7'b1011011);
    idle(3);

    // shift mode, counts 3 (neg), 2, 7
    step(1, 1, 0, 1, 1, 7'b0000111);
    step(1, 0, 0, 0, 0, 7'b0000011);
    step(1, 0, 1, 0, 0, 7'h7F);
    idle(3);

    // same frame with two bubbles
    step(1, 1, 0, 1, 1, 7'b0000111);
    idle(1);
    step(1, 0, 0, 0, 0, 7'b0000011);
    idle(1);
    step(1, 0, 1, 0, 0, 7'h7F);
    idle(3);

    // add mode, back-to-back frames
    step(1, 1, 0, 0, 0, 7'h7F);
    step(1, 0, 0, 0, 1, 7'h7F);
    step(1, 0, 0, 0, 1, 7'h7F);
    step(1, 0, 1, 0, 1, 7'h7F);
    step(1, 1, 1, 0, 0, 7'h01);
    idle(3);

    // overflow in the 6-bit configurations, then a clean frame
    step(1, 1, 0, 0, 1, 7'h7F);
    step(1, 0, 0, 0, 0, 7'h7F);
    step(1, 0, 1, 0, 0, 7'h7F);
    idle(2);
    step(1, 1, 1, 0, 0, 7'h03);
    idle(3);

    // framing errors
    step(1, 0, 1, 0, 0, 7'h0F);
    idle(2);
    step(1, 1, 0, 0, 0, 7'h7F);
    step(1, 0, 0, 0, 0, 7'h7F);
    step(1, 1, 0, 0, 0, 7'h01);
    step(1, 0, 1, 0, 0, 7'h03);
    idle(3);

    // reset mid-frame
    step(1, 1, 0, 0, 0, 7'h7F);
    step(1, 0, 0, 0, 0, 7'h7F);
    do_reset();
    idle(2);
    step(1, 1, 1, 0, 0, 7'h7F);
    idle(3);

    // randomized beats
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 3) != 0,
           $urandom_range(0, 4) == 0,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 2) == 0,
           $urandom_range(0, 1) == 1,
           7'($urandom));
    end
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cprs_col_acc.md
# cprs_col_acc

Parametrised column compressor-accumulator for the bit-serial MAC datapath. Each valid beat reduces an N-bit column (one bit plane of N products) to a population count through the compressor tree and folds it into a signed accumulator. Folding is either a plain add or a shift-and-add for MSB-first bit-serial weighting, with per-plane negation for two's-complement MSB planes. The block is pipelined and framed (first/last), emits one result per frame, and replaces fixed-width 7:2 compressor instances where a full column sum is needed.

## Interface
- N, 7: column width (bits per beat), 2..64.
- ACC_W, 16: accumulator and result width (signed), ≥ CNT_W+1 where CNT_W = clog2(N+1).
- SAT, 1: 1 = saturate on overflow, 0 = two's-complement wrap.
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  beat qualifier.
- in_first  in  1  first plane of frame (valid beats only).
- in_last  in  1  last plane of frame (valid beats only).
- in_neg  in  1  subtract this plane's count instead of adding.
- mode  in  1  0 = add, 1 = shift-and-add; sampled on the in_first beat, held for the frame.
- in_bits  in  N  column bits.
- out_valid  out  1  one-cycle pulse, result available.
- out_sum  out  ACC_W  signed frame result; held until the next out_valid.
- out_ovf  out  1  overflow occurred in this frame; same timing as out_sum.
- drop  out  1  one-cycle pulse: a valid beat was discarded.

## Operation
- Stage 1 (registered): cnt = popcount(in_bits), CNT_W bits, zero-extended. valid/first/last/neg/mode are pipelined alongside.
- Stage 2 (accumulator): FSM with states IDLE and ACCUM.
  - IDLE: a stage-1 beat with first=1 loads acc = neg ? −cnt : +cnt, latches mode, clears ovf, and moves to ACCUM. A beat with first=0 is discarded and drop pulses.
  - ACCUM: beat with first=0 gives acc = (mode ? acc<<1 : acc) ± cnt. Beat with first=1 restarts the frame: the partial result is discarded, the load happens as in IDLE, and drop pulses.
  - A beat with last=1 (including first&last) completes the update. The result goes to out_sum and out_ovf, out_valid pulses, and the FSM returns to IDLE.
- Arithmetic is done at ACC_W+2 bits, then range-checked against the signed ACC_W range.
  - Out of range sets sticky ovf.
  - SAT=1: result clamps to 2^(ACC_W−1)−1 or −2^(ACC_W−1).
  - SAT=0: result keeps the low ACC_W bits.
  - The clamped or wrapped value is what the next beat builds on.
- Bubbles (in_valid=0) leave all state unchanged. Frames may contain any number of bubbles.

## Timing
- Latency: a valid beat at input edge t is counted at t+1 and accumulated at t+2. out_valid for the in_last beat asserts in the cycle after edge t+2.
- Throughput: one beat per cycle, with no backpressure. Back-to-back frames (last then first on consecutive cycles) are supported with no gap.
- drop asserts in the same cycle the stage-2 update would have occurred, which is 2 cycles after the input.
- Reset values: out_valid=0, out_sum=0, out_ovf=0, drop=0, FSM=IDLE, acc=0, and all stage-1 valids cleared.
- Reset mid-frame: in-flight beats are lost and no out_valid is produced. The first beat accepted after rst deasserts must carry in_first.
- in_first/in_last/in_neg/mode are ignored when in_valid=0.

## Test plan
- Single-plane frame (N=7, ACC_W=16, SAT=1): in_bits=7'b1011011, first=last=1, neg=0 at cycle t -> out_valid after edge t+2, out_sum=5, out_ovf=0. Same with neg=1 -> out_sum=−5 (16'hFFFB).
- Shift mode, 3 planes MSB-first, counts 3 (neg=1), 2, 7 -> partials −3, −4, −1, out_sum=−1 (16'hFFFF). Repeat with two bubbles inserted -> identical result, out_valid delayed by 2.
- Add mode with back-to-back frames: frame A is 4×7'h7F, so out_sum=28. Frame B, starting the next cycle, is one 7'h01, so out_sum=1. Expect out_valid on two cycles 1 apart, with no drop.
- Overflow (ACC_W=6, shift mode, 3 planes of 7'h7F, partials 7, 21, 49):
  - SAT=1 -> out_sum=31, out_ovf=1.
  - SAT=0 -> out_sum=6'b110001 (−15), out_ovf=1.
  - Next clean frame -> out_ovf=0.
- Framing errors:
  - Valid beat without first in IDLE -> drop pulse, no out_valid.
  - first mid-frame -> drop pulse; the result reflects only the new frame.
- Reset mid-frame: rst high for 1 cycle after 2 beats -> no out_valid, all outputs 0. A following 1-plane frame of 7'h7F -> out_sum=7.
